procyon_mdu: RTL and testbench

//   Multiply/divide functional unit for RV32M/RV64M ops. Sits beside the integer execution unit behind its own reservation station.

---
 rtl/procyon_mdu_if.sv | 42 ++++
 rtl/procyon_mdu.sv | 279 +++++++++++++++++++++++++++
 tb/tb_procyon_mdu.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/procyon_mdu_if.sv
// Op type shared by the MDU and its issue logic, plus the issue/CDB bundle
// between the reservation station, the MDU and the common data bus.
package procyon_mdu_pkg;
  typedef enum logic [3:0] {
    OP_MUL    = 4'd0,
    OP_MULH   = 4'd1,
    OP_MULHSU = 4'd2,
    OP_MULHU  = 4'd3,
    OP_DIV    = 4'd4,
    OP_DIVU   = 4'd5,
    OP_REM    = 4'd6,
    OP_REMU   = 4'd7,
    OP_NONE   = 4'd15
  } pcyn_op_t;
endpackage

interface procyon_mdu_if
  import procyon_mdu_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RIW = 5
);
  logic                    i_fu_valid;
  pcyn_op_t                i_fu_op;
  logic [1:0][DW-1:0]      i_fu_src;
  logic [RIW-1:0]          i_fu_tag;
  logic                    o_fu_stall;
  logic                    o_cdb_en;
  logic                    o_cdb_redirect;
  logic [DW-1:0]           o_cdb_data;
  logic [RIW-1:0]          o_cdb_tag;

  modport slave (
    input  i_fu_valid, i_fu_op, i_fu_src, i_fu_tag,
    output o_fu_stall, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_tag
  );

  modport master (
    output i_fu_valid, i_fu_op, i_fu_src, i_fu_tag,
    input  o_fu_stall, o_cdb_en, o_cdb_redirect, o_cdb_data, o_cdb_tag
  );
endinterface

// File: rtl/procyon_mdu.sv
// RV32M/RV64M multiply/divide unit: pipelined multiplier plus an iterative
// radix-2 restoring divider, both writing one tagged result per cycle to the CDB.
module procyon_mdu_chk (
  input logic clk,
  input logic n_rst,
  input logic mul_v_i,
  input logic div_done_i
);
  // The stall keeps the mul pipe empty whenever the divider finishes
  a_no_cdb_collision: assert property (@(posedge clk) disable iff (!n_rst) !(mul_v_i && div_done_i))
    else $error("procyon_mdu: mul result and div result competing for the CDB");
endmodule

module procyon_mdu
  import procyon_mdu_pkg::*;
#(
  parameter int OPTN_DATA_WIDTH    = 32,
  parameter int OPTN_ROB_IDX_WIDTH = 5,
  parameter int OPTN_MUL_STAGES    = 2
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              i_flush,
  procyon_mdu_if.slave      fu
);
  localparam int DW  = OPTN_DATA_WIDTH;
  localparam int RIW = OPTN_ROB_IDX_WIDTH;
  localparam int MS  = OPTN_MUL_STAGES;
  localparam int CW  = $clog2(DW + 1);
  localparam int PW  = 2 * DW + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  div_state_t           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DW-1:0]        dvd_q, dvd_d;
  logic [DW-1:0]        dvs_q, dvs_d;
  logic [DW-1:0]        rem_q, rem_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 is_rem_q, is_rem_d;
  logic                 special_q, special_d;
  logic [DW-1:0]        special_res_q, special_res_d;
  logic [RIW-1:0]       div_tag_q, div_tag_d;

  logic                 cdb_en_q, cdb_en_d;
  logic [DW-1:0]        cdb_data_q, cdb_data_d;
  logic [RIW-1:0]       cdb_tag_q, cdb_tag_d;

  logic [DW-1:0]        rs1_s, rs2_s;
  logic                 stall_s, accept_s, is_div_s, div_signed_s, div_is_rem_s;
  logic                 rs1_neg_s, rs2_neg_s;
  logic [DW-1:0]        rs1_abs_s, rs2_abs_s;
  logic [DW:0]          rem_shift_s, diff_s;
  logic [DW-1:0]        div_res_s;
  logic                 mul_a_sgn_s, mul_b_sgn_s;
  logic signed [PW-1:0] mul_a_s, mul_b_s, mul_p_s;
  logic [DW-1:0]        mul_res_s;
  logic [1:0]           mul_unused_s;
  logic                 mul_in_v_s, mul_last_v_s;
  logic [DW-1:0]        mul_last_d_s;
  logic [RIW-1:0]       mul_last_t_s;

  assign rs1_s    = fu.i_fu_src[0];
  assign rs2_s    = fu.i_fu_src[1];
  assign stall_s  = (state_q != S_IDLE);
  assign accept_s = fu.i_fu_valid & ~stall_s & ~i_flush;
  assign is_div_s = fu.i_fu_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign div_signed_s = (fu.i_fu_op == OP_DIV) || (fu.i_fu_op == OP_REM);
  assign div_is_rem_s = (fu.i_fu_op == OP_REM) || (fu.i_fu_op == OP_REMU);
  assign rs1_neg_s = div_signed_s & rs1_s[DW-1];
  assign rs2_neg_s = div_signed_s & rs2_s[DW-1];
  assign rs1_abs_s = rs1_neg_s ? -rs1_s : rs1_s;
  assign rs2_abs_s = rs2_neg_s ? -rs2_s : rs2_s;

  // Multiplier: operands extended to 2*DW+2 bits so every op is one signed product
  always_comb begin
    mul_a_sgn_s = (fu.i_fu_op == OP_MULH) || (fu.i_fu_op == OP_MULHSU);
    mul_b_sgn_s = (fu.i_fu_op == OP_MULH);
    mul_a_s     = {{(DW + 2){mul_a_sgn_s & rs1_s[DW-1]}}, rs1_s};
    mul_b_s     = {{(DW + 2){mul_b_sgn_s & rs2_s[DW-1]}}, rs2_s};
    mul_p_s     = mul_a_s * mul_b_s;
    mul_unused_s = mul_p_s[PW-1:2*DW];
    case (fu.i_fu_op)
      OP_MUL:                        mul_res_s = mul_p_s[DW-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  mul_res_s = mul_p_s[2*DW-1:DW];
      default:                       mul_res_s = '0;
    endcase
  end

  // Anything that is not a divide rides the mul pipe so the ROB always gets an answer
  assign mul_in_v_s = accept_s & ~is_div_s;

  generate
    if (MS == 1) begin : g_mul_direct
      assign mul_last_v_s = mul_in_v_s;
      assign mul_last_d_s = mul_res_s;
      assign mul_last_t_s = fu.i_fu_tag;
    end else begin : g_mul_pipe
      logic [MS-2:0]  pv_q;
      logic [DW-1:0]  pd_q [MS-1];
      logic [RIW-1:0] pt_q [MS-1];

      // Delay line for mul results; flush drops every valid bit at once
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          pv_q <= '0;
          for (int i = 0; i < MS - 1; i++) begin
            pd_q[i] <= '0;
            pt_q[i] <= '0;
          end
        end else begin
          pv_q[0] <= mul_in_v_s & ~i_flush;
          pd_q[0] <= mul_res_s;
          pt_q[0] <= fu.i_fu_tag;
          for (int i = 1; i < MS - 1; i++) begin
            pv_q[i] <= pv_q[i-1] & ~i_flush;
            pd_q[i] <= pd_q[i-1];
            pt_q[i] <= pt_q[i-1];
          end
        end
      end

      assign mul_last_v_s = pv_q[MS-2];
      assign mul_last_d_s = pd_q[MS-2];
      assign mul_last_t_s = pt_q[MS-2];
    end
  endgenerate

  assign rem_shift_s = {rem_q, dvd_q[DW-1]};
  assign diff_s      = rem_shift_s - {1'b0, dvs_q};

  // Divider next state: latch magnitudes, shift/subtract DW times, then sign-fix
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    rem_d         = rem_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    is_rem_d      = is_rem_q;
    special_d     = special_q;
    special_res_d = special_res_q;
    div_tag_d     = div_tag_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s && is_div_s) begin
          state_d   = S_BUSY;
          cnt_d     = CW'(DW);
          dvd_d     = rs1_abs_s;
          dvs_d     = rs2_abs_s;
          rem_d     = '0;
          neg_quo_d = rs1_neg_s ^ rs2_neg_s;
          neg_rem_d = rs1_neg_s;
          is_rem_d  = div_is_rem_s;
          div_tag_d = fu.i_fu_tag;
          if (rs2_s == '0) begin
            special_d     = 1'b1;
            special_res_d = div_is_rem_s ? rs1_s : '1;
          end else if (div_signed_s && (rs1_s == {1'b1, {(DW - 1){1'b0}}}) && (rs2_s == '1)) begin
            special_d     = 1'b1;
            special_res_d = div_is_rem_s ? '0 : rs1_s;
          end else begin
            special_d     = 1'b0;
            special_res_d = '0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (!diff_s[DW]) begin
          rem_d = diff_s[DW-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b1};
        end else begin
          rem_d = rem_shift_s[DW-1:0];
          dvd_d = {dvd_q[DW-2:0], 1'b0};
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (i_flush) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Final divide result with sign correction, valid while in DONE
  always_comb begin
    if (special_q) begin
      div_res_s = special_res_q;
    end else if (is_rem_q) begin
      div_res_s = neg_rem_q ? -rem_q : rem_q;
    end else begin
      div_res_s = neg_quo_q ? -dvd_q : dvd_q;
    end
  end

  // CDB source select; the divider and mul pipe never finish together
  always_comb begin
    cdb_en_d   = 1'b0;
    cdb_data_d = cdb_data_q;
    cdb_tag_d  = cdb_tag_q;
    if (i_flush) begin
      cdb_en_d = 1'b0;
    end else if (state_q == S_DONE) begin
      cdb_en_d   = 1'b1;
      cdb_data_d = div_res_s;
      cdb_tag_d  = div_tag_q;
    end else if (mul_last_v_s) begin
      cdb_en_d   = 1'b1;
      cdb_data_d = mul_last_d_s;
      cdb_tag_d  = mul_last_t_s;
    end else begin
      cdb_en_d = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      rem_q         <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      is_rem_q      <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      div_tag_q     <= '0;
      cdb_en_q      <= 1'b0;
      cdb_data_q    <= '0;
      cdb_tag_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      rem_q         <= rem_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      is_rem_q      <= is_rem_d;
      special_q     <= special_d;
      special_res_q <= special_res_d;
      div_tag_q     <= div_tag_d;
      cdb_en_q      <= cdb_en_d;
      cdb_data_q    <= cdb_data_d;
      cdb_tag_q     <= cdb_tag_d;
    end
  end

  assign fu.o_fu_stall     = stall_s;
  assign fu.o_cdb_en       = cdb_en_q;
  assign fu.o_cdb_redirect = 1'b0;
  assign fu.o_cdb_data     = cdb_data_q;
  assign fu.o_cdb_tag      = cdb_tag_q;

  procyon_mdu_chk u_chk (
    .clk        (clk),
    .n_rst      (n_rst),
    .mul_v_i    (mul_last_v_s),
    .div_done_i (state_q == S_DONE)
  );
endmodule

// File: tb/tb_procyon_mdu.sv
// Directed and random checks of procyon_mdu against an arithmetic reference
// model with a per-cycle expected-CDB schedule.
module tb_procyon_mdu;
  import procyon_mdu_pkg::*;

  localparam int DW   = 32;
  localparam int RIW  = 5;
  localparam int MS   = 2;
  localparam int MAXC = 4000;

  logic clk;
  logic n_rst;
  logic i_flush;
  int   checks;
  int   failures;
  int   cyc;
  int   busy_end;
  bit             exp_en   [MAXC];
  logic [DW-1:0]  exp_data [MAXC];
  logic [RIW-1:0] exp_tag  [MAXC];

  procyon_mdu_if #(.DW(DW), .RIW(RIW)) bus ();

  procyon_mdu #(
    .OPTN_DATA_WIDTH    (DW),
    .OPTN_ROB_IDX_WIDTH (RIW),
    .OPTN_MUL_STAGES    (MS)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_flush (i_flush),
    .fu      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(pcyn_op_t op, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int ia, ib;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ia = a;
    ib = b;
    r  = 32'd0;
    case (op)
      OP_MUL:    begin p = sa * sb; r = p[31:0];  end
      OP_MULH:   begin p = sa * sb; r = p[63:32]; end
      OP_MULHSU: begin p = sa * ub; r = p[63:32]; end
      OP_MULHU:  begin p = ua * ub; r = p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
        else r = ia / ib;
      end
      OP_DIVU: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else r = ia % ib;
      end
      OP_REMU: r = (b == 32'd0) ? a : a % b;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic sched(input int c, input logic [31:0] d, input logic [4:0] t);
    if (c < MAXC) begin
      exp_en[c]   = 1'b1;
      exp_data[c] = d;
      exp_tag[c]  = t;
    end
  endtask

  task automatic check_outputs();
    chk("stall", 64'(bus.o_fu_stall), 64'(cyc <= busy_end));
    chk("cdb_en", 64'(bus.o_cdb_en), 64'(exp_en[cyc]));
    chk("redirect", 64'(bus.o_cdb_redirect), 64'd0);
    if (exp_en[cyc]) begin
      chk("cdb_data", 64'(bus.o_cdb_data), 64'(exp_data[cyc]));
      chk("cdb_tag", 64'(bus.o_cdb_tag), 64'(exp_tag[cyc]));
    end
  endtask

  // One clock cycle: check this cycle's outputs, drive inputs, update the model
  task automatic cycle(input bit v, input pcyn_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tag, input bit fl);
    bit stalled;
    check_outputs();
    bus.i_fu_valid  = v;
    bus.i_fu_op     = op;
    bus.i_fu_src[0] = a;
    bus.i_fu_src[1] = b;
    bus.i_fu_tag    = tag;
    i_flush         = fl;
    stalled = (cyc <= busy_end);
    if (fl) begin
      for (int c = cyc + 1; c < MAXC; c++) exp_en[c] = 1'b0;
      if (busy_end > cyc) busy_end = cyc;
    end else if (v && !stalled && n_rst) begin
      if (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
        sched(cyc + DW + 2, ref_result(op, a, b), tag);
        busy_end = cyc + DW + 1;
      end else begin
        sched(cyc + MS, ref_result(op, a, b), tag);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, OP_MUL, 32'd0, 32'd0, 5'd0, 1'b0);
  endtask

  task automatic async_reset();
    n_rst = 1'b0;
    #1;
    for (int c = cyc; c < MAXC; c++) exp_en[c] = 1'b0;
    busy_end = cyc - 1;
    chk("rst_cdb_en", 64'(bus.o_cdb_en), 64'd0);
    chk("rst_stall", 64'(bus.o_fu_stall), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] v;
    case ($urandom_range(0, 5))
      0:       v = 32'd0;
      1:       v = 32'hFFFF_FFFF;
      2:       v = 32'h8000_0000;
      3:       v = 32'($urandom_range(0, 20));
      default: v = $urandom;
    endcase
    return v;
  endfunction

  initial begin
    int r;
    pcyn_op_t op;
    checks   = 0;
    failures = 0;
    cyc      = 0;
    busy_end = -1;
    n_rst    = 1'b0;
    i_flush  = 1'b0;
    bus.i_fu_valid  = 1'b0;
    bus.i_fu_op     = OP_MUL;
    bus.i_fu_src[0] = 32'd0;
    bus.i_fu_src[1] = 32'd0;
    bus.i_fu_tag    = 5'd0;
    @(posedge clk);
    #1;
    idle(3);
    n_rst = 1'b1;
    idle(2);

    // MUL 7 x -3
    cycle(1'b1, OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd3, 1'b0);
    idle(3);
    // Back-to-back high multiplies
    cycle(1'b1, OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 1'b0);
    cycle(1'b1, OP_MULH, 32'h8000_0000, 32'd2, 5'd5, 1'b0);
    cycle(1'b1, OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b0);
    cycle(1'b1, OP_NONE, 32'd9, 32'd9, 5'd7, 1'b0);
    idle(3);
    // Signed divide and remainder, with a rejected issue while stalled
    cycle(1'b1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b0);
    cycle(1'b1, OP_MUL, 32'd1, 32'd1, 5'd9, 1'b0);
    idle(33);
    cycle(1'b1, OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 1'b0);
    idle(35);
    // Divide special cases
    cycle(1'b1, OP_DIVU, 32'd5, 32'd0, 5'd11, 1'b0);
    idle(34);
    cycle(1'b1, OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 1'b0);
    idle(34);
    cycle(1'b1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    idle(34);
    cycle(1'b1, OP_REMU, 32'd77, 32'd0, 5'd14, 1'b0);
    idle(35);
    // Flush a divide in BUSY cycle 10; the MUL offered with the flush is dropped
    cycle(1'b1, OP_DIV, 32'd1000, 32'd7, 5'd15, 1'b0);
    idle(9);
    cycle(1'b1, OP_MUL, 32'd3, 32'd3, 5'd16, 1'b1);
    cycle(1'b1, OP_MUL, 32'd6, 32'd7, 5'd17, 1'b0);
    idle(40);
    // Reset with a MUL result pending and a DIV busy
    cycle(1'b1, OP_MUL, 32'd11, 32'd12, 5'd18, 1'b0);
    cycle(1'b1, OP_DIVU, 32'd100, 32'd3, 5'd19, 1'b0);
    async_reset();
    idle(2);
    n_rst = 1'b1;
    idle(40);

    // Random traffic with occasional flushes
    for (int i = 0; i < 900; i++) begin
      r  = $urandom_range(0, 8);
      op = (r == 8) ? OP_NONE : pcyn_op_t'(r[3:0]);
      cycle(($urandom_range(0, 9) < 7), op, pick(), pick(), 5'($urandom_range(0, 31)),
            ($urandom_range(0, 59) == 0));
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
